// File: rtl/soc_wb_sram_slave.sv
// Wishbone B3 slave over a word-addressed SRAM: classic cycles with one wait state and
// registered-feedback incrementing bursts (linear, wrap-4/8/16); out-of-range accesses end with err_o.
module soc_wb_sram_slave #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  input  logic                    we_i,
  input  logic [2:0]              cti_i,
  input  logic [1:0]              bte_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic                    ack_o,
  output logic                    err_o,
  output logic                    rty_o
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IW        = $clog2(MEM_WORDS);
  localparam int SL        = $clog2(SEL_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CLASSIC, S_BURST} state_e;

  state_e                state_q;
  logic                  ack_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [IW-1:0]         a_q;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                  req;
  logic                  hit;
  logic                  is_classic;
  logic                  beat_done;
  logic                  nxt_ok;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] word_off;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         wrap_mask;
  logic [IW-1:0]         a_d;
  logic [IW-1:0]         rd_idx;
  logic [IW-1:0]         wr_idx;
  logic [IW:0]           lin_d;

  assign req        = cyc_i & stb_i;
  assign word_off   = (adr_i - BASE_ADDR) >> SL;
  assign hit        = (adr_i >= BASE_ADDR) && (word_off[ADDR_WIDTH-1:IW] == '0);
  assign idx        = word_off[IW-1:0];
  assign is_classic = (cti_i == 3'b000) || (cti_i == 3'b111);
  // A beat completes on the edge where our ack meets a still-asserted strobe.
  assign beat_done  = (state_q == S_BURST) && ack_q && req;

  always_comb begin
    case (bte_i)
      2'b01:   wrap_mask = IW'(3);
      2'b10:   wrap_mask = IW'(7);
      2'b11:   wrap_mask = IW'(15);
      default: wrap_mask = '0;
    endcase
  end

  // Linear stepping keeps the carry so the last word never wraps back to 0.
  assign lin_d  = {1'b0, a_q} + (IW+1)'(1);
  assign a_d    = (bte_i == 2'b00) ? lin_d[IW-1:0]
                                   : ((a_q & ~wrap_mask) | (lin_d[IW-1:0] & wrap_mask));
  assign nxt_ok = (bte_i != 2'b00) || !lin_d[IW];

  assign rd_idx = (state_q == S_BURST) ? (beat_done ? a_d : a_q) : idx;
  assign wr_idx = (state_q == S_BURST) ? a_q : idx;
  assign mem_we = rst_ni && we_i &&
                  (((state_q == S_IDLE) && req && hit && is_classic) || beat_done);

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < SEL_WIDTH; b++) begin
        if (sel_i[b]) mem[wr_idx][b*8 +: 8] <= dat_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      a_q     <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req && is_classic) begin
            state_q <= S_CLASSIC;
            ack_q   <= hit;
            err_q   <= !hit;
            dat_q   <= mem[rd_idx];
          end else if (req && cti_i == 3'b010) begin
            if (hit) begin
              state_q <= S_BURST;
              a_q     <= idx;
              ack_q   <= 1'b1;
              dat_q   <= mem[rd_idx];
            end else begin
              state_q <= S_CLASSIC;
              err_q   <= 1'b1;
            end
          end
        end
        S_CLASSIC: state_q <= S_IDLE;
        S_BURST: begin
          if (!cyc_i) begin
            state_q <= S_IDLE;
          end else if (beat_done) begin
            if (cti_i != 3'b010) begin
              state_q <= S_IDLE;
            end else if (!nxt_ok) begin
              state_q <= S_CLASSIC;
              err_q   <= 1'b1;
            end else begin
              a_q   <= a_d;
              ack_q <= 1'b1;
              dat_q <= mem[rd_idx];
            end
          end else if (req) begin
            // Resuming after a master wait: re-issue the pending beat at a_q.
            ack_q <= 1'b1;
            dat_q <= mem[rd_idx];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dat_o = dat_q;
  assign ack_o = ack_q;
  assign err_o = err_q;
  assign rty_o = 1'b0;
endmodule

// File: tb/tb_soc_wb_sram_slave.sv
// Directed and randomized checks of soc_wb_sram_slave against a word-array reference model.
module tb_soc_wb_sram_slave;
  localparam int          MW   = 64;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;
  logic        err;
  logic        rty;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] model [MW];

  soc_wb_sram_slave #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .MEM_WORDS (MW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .adr_i (adr),
    .dat_i (dat_w),
    .cyc_i (cyc),
    .stb_i (stb),
    .sel_i (sel),
    .we_i  (we),
    .cti_i (cti),
    .bte_i (bte),
    .dat_o (dat_r),
    .ack_o (ack),
    .err_o (err),
    .rty_o (rty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop();
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    cti = 3'b000;
  endtask

  // Burst address rule: linear counts up without wrapping; wrapN stays inside its aligned N-word block.
  function automatic int next_idx(input int a, input int bt);
    int n;
    if (bt == 0) return a + 1;
    n = 4 << (bt - 1);
    return (a - a % n) + ((a % n) + 1) % n;
  endfunction

  task automatic set_beat(input int a, input bit last, input int wr_pct);
    adr   = BASE + 32'(a) * 32'd4;
    cti   = last ? 3'b111 : 3'b010;
    we    = ($urandom_range(99) < wr_pct);
    dat_w = $urandom;
    sel   = 4'($urandom);
  endtask

  task automatic classic(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input string tag, output logic [31:0] got);
    logic in_r;
    int   idx;
    in_r = (a >= BASE) && ((a - BASE) < 32'(MW * 4));
    idx  = in_r ? int'((a - BASE) >> 2) : 0;
    adr = a; we = w; dat_w = d; sel = s; cti = 3'b000; bte = 2'b00;
    cyc = 1'b1; stb = 1'b1;
    tick();
    got = dat_r;
    check({tag, ".ack"}, 32'(ack), 32'(in_r));
    check({tag, ".err"}, 32'(err), 32'(!in_r));
    if (in_r && !w) check({tag, ".dat"}, dat_r, model[idx]);
    if (in_r && w) begin
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
    end
    drop();
    tick();
    check({tag, ".one"}, {30'd0, ack, err}, 32'd0);
  endtask

  // Registered-feedback master: a beat completes on the edge after an ack seen with stb high.
  task automatic burst(input int start, input int bt, input int nbeats, input int wr_pct,
                       input int gap_after, input int gap_len, input int rst_beat, input string tag);
    int   a;
    int   done;
    int   budget;
    int   gap_left;
    logic live;
    logic stb_prev;
    logic ack_s;
    logic in_r;
    a = start; done = 0; budget = 0; gap_left = 0; live = 1'b1;
    bte = 2'(bt);
    set_beat(a, nbeats == 1, wr_pct);
    cyc = 1'b1; stb = 1'b1;
    stb_prev = 1'b1; ack_s = 1'b0;
    while (live && budget < 100) begin
      tick();
      budget++;
      if (stb_prev && ack_s) begin
        if (we) begin
          for (int b = 0; b < 4; b++) if (sel[b]) model[a][b*8 +: 8] = dat_w[b*8 +: 8];
        end
        done++;
        a = next_idx(a, bt);
        if (done == nbeats) begin
          drop();
          live = 1'b0;
        end else begin
          set_beat(a, done == nbeats - 1, wr_pct);
          if (done == gap_after) begin
            stb = 1'b0;
            gap_left = gap_len;
          end
        end
      end else if (!stb && gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) stb = 1'b1;
      end
      if (live) begin
        ack_s = ack;
        if (stb || !stb_prev) begin
          in_r = (a < MW);
          check({tag, ".ack"}, 32'(ack), 32'(stb_prev && in_r));
          check({tag, ".err"}, 32'(err), 32'(stb_prev && !in_r));
          if (stb_prev && in_r && !we) check({tag, ".dat"}, dat_r, model[a]);
          if (stb_prev && !in_r) begin
            drop();
            live = 1'b0;
          end
        end
        if (live && rst_beat == done && stb && ack) begin
          rst_n = 1'b0;
          tick();
          check({tag, ".rst_resp"}, {30'd0, ack, err}, 32'd0);
          check({tag, ".rst_dat"}, dat_r, 32'd0);
          rst_n = 1'b1;
          drop();
          live = 1'b0;
        end
      end
      stb_prev = stb;
    end
    check({tag, ".fin"}, 32'(live), 32'd0);
    if (live) drop();
    tick();
    check({tag, ".idle"}, {30'd0, ack, err}, 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    int          i;
    rst_n = 1'b0; adr = '0; dat_w = '0; cyc = 1'b0; stb = 1'b0;
    we = 1'b0; sel = '0; cti = '0; bte = '0;
    tick();
    tick();
    check("rst.ack", 32'(ack), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.dat", dat_r, 32'd0);
    check("rst.rty", 32'(rty), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < MW; k++) classic(BASE + 32'(k) * 32'd4, 1'b1, $urandom, 4'hF, "fill", got);

    classic(BASE + 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, "t1.wr", got);
    classic(BASE + 32'h10, 1'b0, 32'd0, 4'hF, "t1.rd", got);
    check("t1.val", got, 32'hDEADBEEF);

    classic(BASE + 32'h20, 1'b1, 32'h11223344, 4'hF, "t2.wr", got);
    classic(BASE + 32'h20, 1'b1, 32'h0000AB00, 4'b0010, "t2.byte", got);
    classic(BASE + 32'h20, 1'b0, 32'd0, 4'hF, "t2.rd", got);
    check("t2.val", got, 32'h1122AB44);

    burst(6, 1, 4, 0, -1, 0, -1, "t3.wrap4");
    burst(20, 0, 5, 0, 2, 2, -1, "t4.gap");

    classic(BASE + 32'(MW * 4), 1'b0, 32'd0, 4'hF, "t5.rd_hi", got);
    classic(BASE + 32'(MW * 4), 1'b1, 32'hA5A5A5A5, 4'hF, "t5.wr_hi", got);
    classic(BASE - 32'd4, 1'b1, 32'h5A5A5A5A, 4'hF, "t5.wr_lo", got);
    classic(BASE, 1'b0, 32'd0, 4'hF, "t5.w0", got);
    classic(BASE + 32'(MW * 4 - 4), 1'b0, 32'd0, 4'hF, "t5.wlast", got);

    burst(61, 0, 5, 50, -1, 0, -1, "lin_end");
    burst(13, 2, 8, 50, 3, 1, -1, "wrap8");
    burst(35, 3, 16, 50, -1, 0, -1, "wrap16");

    burst(30, 0, 8, 0, -1, 0, 2, "t6.rst");
    classic(BASE + 32'd120, 1'b0, 32'd0, 4'hF, "t6.after", got);

    repeat (60) begin
      if ($urandom_range(1) == 1) begin
        burst(int'($urandom_range(MW - 1)), int'($urandom_range(3)), int'($urandom_range(1, 12)),
              50, int'($urandom_range(11)), int'($urandom_range(1, 3)), -1, "rnd.burst");
      end else begin
        i = int'($urandom_range(MW + 3)) - 2;
        classic(BASE + 32'(i * 4), 1'($urandom), $urandom, 4'($urandom), "rnd.classic", got);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
